clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
- Upstream input stage of the clock top level, between the raw board push-buttons and the timekeeping counter.
- Synchronises and debounces the five user buttons: write, value-increment, value-decrement, select-increment and select-decrement.
- Runs the time-set state machine and produces the field select, edited BCD value and single-cycle write strobe consumed by the hh/mm/ss counter.

Parameters:
- DEBOUNCE_CYCLES, 600000, consecutive stable cycles before a button level is accepted (50 ms at 12 MHz).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- i_clk  in  1  system clock, 12 MHz.
- i_reset  in  1  synchronous, active-high reset.
- i_wr_btn  in  1  raw write button, async, active-high.
- i_val_inc_btn  in  1  raw value-increment button.
- i_val_dec_btn  in  1  raw value-decrement button.
- i_sel_inc_btn  in  1  raw select-increment button.
- i_sel_dec_btn  in  1  raw select-decrement button.
- i_hh  in  8  live hours, BCD 01..12.
- i_mm  in  8  live minutes, BCD 00..59.
- i_ss  in  8  live seconds, BCD 00..59.
- o_edit  out  1  high while in EDIT.
- o_sel  out  2  field select: 0 = hh, 1 = mm, 2 = ss; 3 is never driven.
- o_val  out  8  BCD value for the selected field.
- o_wr  out  1  one-cycle strobe: load o_val into field o_sel.
- o_input_pulse  out  1  one-cycle strobe per accepted button event.

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_reset); all state changes on the rising edge of i_clk.
- Reset values: o_edit=0, o_sel=2'd0, o_val=8'h00, o_wr=0, o_input_pulse=0, state=IDLE, all debounce counters=0, all stable levels=0, all sync flops=0.
- Reset asserted mid-operation aborts EDIT with no o_wr.

Debounce (per button):
- 2-flop synchroniser feeds the debounce counter.
- Counter clears whenever the synchronised level equals the stable level.
- Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 the stable level takes the new value and the counter clears.
- Rising edge of the stable level gives a one-cycle event in cycle E.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Release produces no event.
- A button held across reset release produces one event after debounce.

Arbitration:
- Fixed priority when several events fall in the same cycle: wr > sel_inc > sel_dec > val_inc > val_dec.
- Only the winning event is acted on; the others are dropped, not queued.

State machine (registers update at the end of E, outputs visible at E+1):
- IDLE + wr: enter EDIT, o_edit=1, o_sel=0, o_val=i_hh.
- IDLE + any other event: ignored, o_input_pulse stays 0.
- EDIT + wr: return to IDLE, o_edit=0, no o_wr.
- EDIT + sel_inc: o_sel goes 0→1→2→0; o_val reloads from the newly selected live field.
- EDIT + sel_dec: o_sel goes 0→2→1→0; o_val reloads from the newly selected live field.
- EDIT + val_inc / val_dec: o_val takes the BCD inc/dec of its current value, with o_wr=1 for exactly cycle E+1 while o_val already holds the new value.

BCD wrap rules:
- hh: 12→01 on increment, 01→12 on decrement.
- mm/ss: 59→00 on increment, 00→59 on decrement.
- Units digit carry/borrow is into the tens digit.
- Out-of-range o_val (e.g. 8'h00 in the hh field) is treated as the lowest legal value before the step.

Other output rules:
- o_input_pulse=1 at E+1 for every event acted on.
- o_wr is never high in two consecutive cycles.
- AM/PM is not touched by this block.

Decomposition:
- Shared package clock_pkg:
  - SEL_HH/SEL_MM/SEL_SS constants.
  - IDLE/EDIT state encoding.
  - BCD limit constants 8'h01, 8'h12, 8'h59.
  - Functions bcd_inc and bcd_dec taking (value, sel).
- One sub-module, button_debounce (synchroniser, counter, stable level, rising-edge event), instantiated five times.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then a 3-cycle pulse on i_wr_btn -> no event; o_edit=0 and all outputs hold their reset values.
- i_hh=8'h11, press wr for 10 cycles -> o_edit=1, o_sel=0, o_val=8'h11; val_inc -> o_val=8'h12 with one o_wr; second val_inc -> o_val=8'h01 with one o_wr.
- In EDIT with i_mm=8'h59, sel_inc -> o_sel=1, o_val=8'h59, no o_wr; val_inc -> o_val=8'h00 with o_wr; two more sel_inc -> o_sel=2, then 0.
- o_sel=0 and i_ss=8'h00, sel_dec -> o_sel=2, o_val=8'h00; val_dec -> o_val=8'h59 with o_wr; wr -> o_edit=0; val_inc in IDLE -> no o_wr, no o_input_pulse.
- val_inc and sel_inc rising in the same cycle in EDIT -> only o_sel advances, no o_wr, exactly one o_input_pulse.
- i_reset for 1 cycle during EDIT while val_inc is held -> reset values at next edge; after 4+2 cycles one event, which is ignored because the block is in IDLE.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, limits and BCD stepping helpers for the clock time-set path.
package clock_pkg;

  typedef enum logic [1:0] {
    SEL_HH = 2'd0,
    SEL_MM = 2'd1,
    SEL_SS = 2'd2
  } sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  localparam logic [7:0] BCD_HH_MIN = 8'h01;
  localparam logic [7:0] BCD_HH_MAX = 8'h12;
  localparam logic [7:0] BCD_MS_MIN = 8'h00;
  localparam logic [7:0] BCD_MS_MAX = 8'h59;

  localparam int BTN_WR      = 0;
  localparam int BTN_VAL_INC = 1;
  localparam int BTN_VAL_DEC = 2;
  localparam int BTN_SEL_INC = 3;
  localparam int BTN_SEL_DEC = 4;
  localparam int BTN_N       = 5;

  function automatic logic [7:0] bcd_lo(input sel_t sel);
    return (sel == SEL_HH) ? BCD_HH_MIN : BCD_MS_MIN;
  endfunction

  function automatic logic [7:0] bcd_hi(input sel_t sel);
    return (sel == SEL_HH) ? BCD_HH_MAX : BCD_MS_MAX;
  endfunction

  // With both digits valid, BCD codes order the same as the numbers they hold.
  function automatic logic [7:0] bcd_clean(input logic [7:0] value, input sel_t sel);
    logic ok;
    ok = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
         (value >= bcd_lo(sel)) && (value <= bcd_hi(sel));
    return ok ? value : bcd_lo(sel);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] value, input sel_t sel);
    logic [7:0] x;
    x = bcd_clean(value, sel);
    if (x == bcd_hi(sel)) return bcd_lo(sel);
    if (x[3:0] == 4'd9) return {x[7:4] + 4'd1, 4'd0};
    return {x[7:4], x[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] value, input sel_t sel);
    logic [7:0] x;
    x = bcd_clean(value, sel);
    if (x == bcd_lo(sel)) return bcd_hi(sel);
    if (x[3:0] == 4'd0) return {x[7:4] - 4'd1, 4'd9};
    return {x[7:4], x[3:0] - 4'd1};
  endfunction

  function automatic sel_t sel_next(input sel_t sel);
    case (sel)
      SEL_HH:  return SEL_MM;
      SEL_MM:  return SEL_SS;
      default: return SEL_HH;
    endcase
  endfunction

  function automatic sel_t sel_prev(input sel_t sel);
    case (sel)
      SEL_HH:  return SEL_SS;
      SEL_SS:  return SEL_MM;
      default: return SEL_HH;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, run-length debounce and press (rising) event for one button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 600000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      evt     <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      evt     <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run.
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_p1;
        cnt    <= '0;
        evt    <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button front end and time-set FSM feeding field select, edited BCD value and write strobe.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 600000,
  parameter int CNT_W           = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_btn,
  input  logic       i_val_inc_btn,
  input  logic       i_val_dec_btn,
  input  logic       i_sel_inc_btn,
  input  logic       i_sel_dec_btn,
  input  logic [7:0] i_hh,
  input  logic [7:0] i_mm,
  input  logic [7:0] i_ss,
  output logic       o_edit,
  output logic [1:0] o_sel,
  output logic [7:0] o_val,
  output logic       o_wr,
  output logic       o_input_pulse
);

  logic [BTN_N-1:0] btn_raw;
  logic [BTN_N-1:0] evt;

  assign btn_raw[BTN_WR]      = i_wr_btn;
  assign btn_raw[BTN_VAL_INC] = i_val_inc_btn;
  assign btn_raw[BTN_VAL_DEC] = i_val_dec_btn;
  assign btn_raw[BTN_SEL_INC] = i_sel_inc_btn;
  assign btn_raw[BTN_SEL_DEC] = i_sel_dec_btn;

  for (genvar g = 0; g < BTN_N; g++) begin : g_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk(i_clk),
      .rst(i_reset),
      .btn(btn_raw[g]),
      .evt(evt[g])
    );
  end

  function automatic logic [7:0] live_field(input sel_t sel, input logic [7:0] hh,
                                            input logic [7:0] mm, input logic [7:0] ss);
    case (sel)
      SEL_MM:  return mm;
      SEL_SS:  return ss;
      default: return hh;
    endcase
  endfunction

  state_t     state_q, state_d;
  sel_t       sel_q, sel_d, sel_new;
  logic [7:0] val_q, val_d;
  logic       wr_q, wr_d;
  logic       pulse_q, pulse_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_HH;
      val_q   <= 8'h00;
      wr_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      wr_q    <= wr_d;
      pulse_q <= pulse_d;
    end
  end

  // Priority wr > sel_inc > sel_dec > val_inc > val_dec; losers are dropped.
  // A value step right after a write is dropped so o_wr never spans two cycles.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    val_d   = val_q;
    wr_d    = 1'b0;
    pulse_d = 1'b0;
    sel_new = sel_q;
    if (evt[BTN_WR]) begin
      pulse_d = 1'b1;
      if (state_q == IDLE) begin
        state_d = EDIT;
        sel_d   = SEL_HH;
        val_d   = i_hh;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == EDIT) begin
      if (evt[BTN_SEL_INC] || evt[BTN_SEL_DEC]) begin
        sel_new = evt[BTN_SEL_INC] ? sel_next(sel_q) : sel_prev(sel_q);
        sel_d   = sel_new;
        val_d   = live_field(sel_new, i_hh, i_mm, i_ss);
        pulse_d = 1'b1;
      end else if ((evt[BTN_VAL_INC] || evt[BTN_VAL_DEC]) && !wr_q) begin
        val_d   = evt[BTN_VAL_INC] ? bcd_inc(val_q, sel_q) : bcd_dec(val_q, sel_q);
        wr_d    = 1'b1;
        pulse_d = 1'b1;
      end
    end
  end

  assign o_edit        = (state_q == EDIT);
  assign o_sel         = sel_q;
  assign o_val         = val_q;
  assign o_wr          = wr_q;
  assign o_input_pulse = pulse_q;

endmodule
